// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Purpose:
//   Receives an 8N1 UART stream on rx, checks the framing and queues the good
//   bytes in a small first-word-fall-through FIFO. A downstream consumer
//   (display or echo logic) pops bytes with rd_en.
//
// Optional feature (macro UART_RX_PARITY_EN):
//   When defined, the frame is 8E1. A PARITY state samples the extra bit
//   between DATA and STOP. Bytes with bad parity are dropped at the stop
//   decision and parity_err pulses for one cycle. When undefined, the frame is
//   8N1 and the parity_err port does not exist.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   rx         in   asynchronous serial input, idles high
//   rd_en      in   pop strobe for the FIFO head, ignored while empty
//   rd_data    out  FIFO head byte, valid while empty=0 (reads 0 when empty)
//   empty      out  FIFO holds no bytes
//   full       out  FIFO holds FIFO_DEPTH bytes
//   count      out  exact FIFO occupancy
//   frame_err  out  one-cycle pulse on a bad stop bit
//   overrun    out  one-cycle pulse when a good byte is dropped (FIFO full)
//   busy       out  high while a frame is in progress (state other than IDLE)
//   parity_err out  one-cycle pulse on a parity mismatch (UART_RX_PARITY_EN)
//
// Read handshake: rd_data/empty act as a valid signal (valid = !empty).
// A pop happens on a rising edge where rd_en=1 and empty=0; rd_en while
// empty is ignored. The head advances on the cycle after the pop.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                          parity_err
`endif
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PH_W  = $clog2(OVERSAMPLE);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0]  PH_A     = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0]  PH_B     = PH_W'(OVERSAMPLE / 2);
    localparam logic [PH_W-1:0]  PH_C     = PH_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t            state;
    logic              rx_meta;
    logic              rx_s;
    logic [1:0]        sync_fill;
    logic              armed;
    logic [DIV_W-1:0]  div_cnt;
    logic [PH_W-1:0]   phase;
    logic              s_a;
    logic              s_b;
    logic [7:0]        shift;
    logic [2:0]        bit_idx;
`ifdef UART_RX_PARITY_EN
    logic              par_bad;
`endif

    logic              active;
    logic              tick;
    logic              decide;
    logic              vote;
    logic              stop_ok;
    logic              push;
    logic              pop;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // The divider and phase counter only run while a frame is being sampled.
    assign active = (state == S_START) || (state == S_DATA) ||
                    (state == S_PARITY) || (state == S_STOP);
    assign tick   = active && (div_cnt == DIV_LAST);
    assign decide = tick && (phase == PH_C);
    // Majority of the three samples around mid-bit; the third is live rx_s.
    assign vote   = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);

`ifdef UART_RX_PARITY_EN
    assign stop_ok = (state == S_STOP) && decide && vote && !par_bad;
`else
    assign stop_ok = (state == S_STOP) && decide && vote;
`endif
    // A full FIFO still accepts the byte when the head is popped this cycle.
    assign push  = stop_ok && (!full || rd_en);
    assign pop   = rd_en && !empty;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign rd_data = empty ? 8'h00 : mem[rd_ptr];
    assign busy    = (state != S_IDLE);

    // Receiver: synchroniser, arming, tick/phase generation and frame FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
            state     <= S_IDLE;
            div_cnt   <= '0;
            phase     <= '0;
            s_a       <= 1'b1;
            s_b       <= 1'b1;
            shift     <= 8'h00;
            bit_idx   <= 3'd0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            // The reset value of the synchroniser is not a real line sample,
            // so arming waits until both stages have been refilled from rx.
            // A line held low through reset therefore stays unarmed.
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && rx_s) begin
                armed <= 1'b1;
            end

            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif

            // Counters sit at zero outside a frame, so leaving IDLE restarts
            // the divider aligned to the start edge.
            if (active) begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                if (tick) begin
                    phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
                    if (phase == PH_A) s_a <= rx_s;
                    if (phase == PH_B) s_b <= rx_s;
                end
            end else begin
                div_cnt <= '0;
                phase   <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (armed && !rx_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (decide) begin
                        // A start bit that does not hold low is a glitch.
                        state   <= vote ? S_IDLE : S_DATA;
                        bit_idx <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (decide) begin
                        shift   <= {vote, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (decide) begin
                        // Even parity: data plus parity bit must XOR to 0.
                        par_bad <= ^{shift, vote};
                        state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (decide) begin
                        if (!vote) begin
                            // Bad stop bit wins over any parity result.
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            if (par_bad) parity_err <= 1'b1;
                            else
`endif
                            if (!push) overrun <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                S_BREAK: begin
                    // Wait out a held-low line so it cannot retrigger frames.
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO storage; pointers wrap naturally since the depth is a power of 2.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shift;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed bench for uart_rx_fifo with CLK_FREQ=1600000, BAUD=10000,
// OVERSAMPLE=16 (DIV=10, 160 clocks per bit). Inputs change 1 time unit
// after a rising edge and outputs are sampled at that same point.
//
// Frame timing used throughout: if the start bit is driven just after edge
// P0, the FSM enters START at P3 and takes the stop-bit decision at edge
// P3 + 100 + 9*160 = P1543, i.e. 103 edges after the stop bit is driven.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int fe_mark;
    int ov_mark;

    uart_rx_fifo #(
        .CLK_FREQ  (1600000),
        .BAUD      (10000),
        .OVERSAMPLE(16),
        .FIFO_DEPTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    // Drives start + 8 data bits (LSB first) and the stop bit, returning one
    // edge before the stop decision.
    task automatic send_to_stop(input logic [7:0] data, input logic stop_bit);
        rx = 1'b0;
        wait_cycles(160);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_cycles(160);
        end
        rx = stop_bit;
        wait_cycles(102);
    endtask

    // Completes the stop bit after the decision edge has been stepped.
    task automatic finish_frame();
        wait_cycles(57);
    endtask

    task automatic send_good(input logic [7:0] data);
        send_to_stop(data, 1'b1);
        step();
        finish_frame();
        wait_cycles(16);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_b;

        reset = 1'b1;
        rx    = 1'b1;
        rd_en = 1'b0;
        wait_cycles(4);

        // Reset state
        check("rst_empty",     32'(empty),     32'd1);
        check("rst_full",      32'(full),      32'd0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_rd_data",   32'(rd_data),   32'h00);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        reset = 1'b0;
        wait_cycles(20);

        // Single byte 0x41
        send_to_stop(8'h41, 1'b1);
        check("single_pre_empty", 32'(empty), 32'd1);
        check("single_pre_busy",  32'(busy),  32'd1);
        step();
        check("single_empty",     32'(empty),     32'd0);
        check("single_rd_data",   32'(rd_data),   32'h41);
        check("single_count",     32'(count),     32'd1);
        check("single_frame_err", 32'(frame_err), 32'd0);
        check("single_overrun",   32'(overrun),   32'd0);
        finish_frame();
        wait_cycles(16);
        pop_one();
        check("single_pop_empty", 32'(empty), 32'd1);
        check("single_pop_count", 32'(count), 32'd0);

        // Burst of 9 bytes with no pops: the 9th overruns
        ov_mark = ov_cnt;
        for (int i = 0; i < 8; i++) begin
            send_good(8'(i));
            if (i == 6) check("burst_7_full", 32'(full), 32'd0);
        end
        check("burst_full",  32'(full),  32'd1);
        check("burst_count", 32'(count), 32'd8);
        send_to_stop(8'h08, 1'b1);
        step();
        check("burst_overrun_pulse", 32'(overrun), 32'd1);
        check("burst_overrun_count", 32'(count),   32'd8);
        finish_frame();
        wait_cycles(16);
        check("burst_overrun_once", 32'(ov_cnt - ov_mark), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("burst_pop_data", 32'(rd_data), 32'(i));
            pop_one();
        end
        check("burst_drained", 32'(empty), 32'd1);

        // Framing error: 0x55 with stop bit low, line held low 5 bit-times
        fe_mark = fe_cnt;
        send_to_stop(8'h55, 1'b0);
        step();
        check("ferr_pulse", 32'(frame_err), 32'd1);
        finish_frame();
        wait_cycles(640);
        check("ferr_busy_low_line", 32'(busy),  32'd1);
        check("ferr_fifo_empty",    32'(empty), 32'd1);
        check("ferr_once",          32'(fe_cnt - fe_mark), 32'd1);
        rx = 1'b1;
        wait_cycles(2);
        check("ferr_busy_sync", 32'(busy), 32'd1);
        step();
        check("ferr_busy_release", 32'(busy), 32'd0);
        wait_cycles(160);
        send_good(8'hA5);
        check("ferr_next_data",  32'(rd_data), 32'hA5);
        check("ferr_next_count", 32'(count),   32'd1);
        pop_one();

        // Glitch rejection: 3-clock low pulse at idle
        fe_mark = fe_cnt;
        rx = 1'b0;
        wait_cycles(3);
        rx = 1'b1;
        wait_cycles(20);
        check("glitch_busy_start", 32'(busy), 32'd1);
        wait_cycles(120);
        check("glitch_busy_idle", 32'(busy),  32'd0);
        check("glitch_no_byte",   32'(empty), 32'd1);
        check("glitch_no_ferr",   32'(fe_cnt - fe_mark), 32'd0);
        send_good(8'h3C);
        check("glitch_next_data", 32'(rd_data), 32'h3C);
        pop_one();
        check("glitch_next_empty", 32'(empty), 32'd1);

        // Full FIFO with a pop on the exact stop-decision cycle
        for (int i = 0; i < 8; i++) begin
            send_good(8'h10 + 8'(i));
        end
        check("fullpp_pre_count", 32'(count), 32'd8);
        ov_mark = ov_cnt;
        send_to_stop(8'h99, 1'b1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("fullpp_count",   32'(count),   32'd8);
        check("fullpp_full",    32'(full),    32'd1);
        check("fullpp_overrun", 32'(overrun), 32'd0);
        check("fullpp_head",    32'(rd_data), 32'h11);
        finish_frame();
        wait_cycles(16);
        check("fullpp_no_overrun", 32'(ov_cnt - ov_mark), 32'd0);
        for (int i = 0; i < 8; i++) begin
            exp_b = (i < 7) ? (8'h11 + 8'(i)) : 8'h99;
            check("fullpp_order", 32'(rd_data), 32'(exp_b));
            pop_one();
        end
        check("fullpp_drained", 32'(empty), 32'd1);

        // Reset mid-frame with the line held low through reset
        send_good(8'h5A);
        check("midrst_pre_count", 32'(count), 32'd1);
        rx = 1'b0;
        wait_cycles(300);
        check("midrst_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        check("midrst_count",   32'(count),   32'd0);
        check("midrst_empty",   32'(empty),   32'd1);
        check("midrst_busy",    32'(busy),    32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'h00);
        wait_cycles(400);
        check("midrst_low_not_decoded", 32'(busy),  32'd0);
        check("midrst_low_no_byte",     32'(empty), 32'd1);
        rx = 1'b1;
        wait_cycles(20);
        send_good(8'hC3);
        check("midrst_next_data",  32'(rd_data), 32'hC3);
        check("midrst_next_count", 32'(count),   32'd1);
        pop_one();
        check("midrst_final_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
